io_interrupt_unit: RTL and testbench
====================================

Name: io_interrupt_unit

Overview:
- Input/output and interrupt stage for the 8-bit Mano datapath.
- Holds INPR/OUTR, the FGI/FGO flags, IEN and the interrupt-cycle flip-flop R.
- Decodes register-reference I/O instructions (D7 & I & T3), exchanges bytes with external devices over valid/ready handshakes, and drives the control unit, AC, PC, AR and SC with interrupt-cycle and I/O control strobes.
- Sits beside the control unit and feeds it; the control unit gates normal fetch with fetch_inhibit.

Parameters:
DATA_W, 8, width of INPR/OUTR/AC byte
ADDR_W, 4, width of AR/PC

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST_N  in  1  synchronous active-low reset
T  in  8  one-hot timing signals from SC decoder
D  in  8  one-hot opcode decode of IR[6:4]
I  in  1  IR[7]
B  in  4  IR[3:0] I/O function field
in_valid  in  1  input device has a byte
in_data  in  DATA_W  input device byte
in_ready  out  1  = ~FGI; device byte accepted when in_valid & in_ready
out_data  out  DATA_W  OUTR contents
out_valid  out  1  = ~FGO; OUTR holds an unread byte
out_ready  in  1  output device takes byte when out_valid & out_ready
ac_in  in  DATA_W  AC value, source for OUT
inpr  out  DATA_W  INPR contents, AC load source for INP
ac_ld_inpr  out  1  load AC <- INPR this cycle
pc_skip  out  1  increment PC (skip) this cycle
sc_clr  out  1  clear sequence counter
fetch_inhibit  out  1  = R; suppress normal T0-T2 fetch
int_ar_clr  out  1  RT0: AR <- 0
int_save_pc  out  1  RT0/RT1: save PC, write it to M[0]
int_pc_clr  out  1  RT1: PC <- 0
int_pc_inr  out  1  RT2: PC <- PC+1
ien  out  1  interrupt enable
fgi, fgo  out  1 each  flags
out_overrun  out  1  one-cycle pulse: OUT executed while FGO=0

Behaviour:
- Reset (RST_N=0 at edge): INPR=0, OUTR=0, FGI=0, FGO=1, IEN=0, R=0; all strobes 0; overrides every other event.
- io = D[7] & I & T[3]. Function codes on B: 8 INP, 4 OUT, 2 SKI, 1 SKO, C ION, 3 IOF; any other code is a no-op that still asserts sc_clr.
- INP: ac_ld_inpr=1 (combinational, same cycle); FGI<=0.
- OUT: OUTR<=ac_in; FGO<=0. If FGO was already 0, OUTR is still overwritten and out_overrun pulses for that cycle.
- SKI: pc_skip=1 iff FGI=1. SKO: pc_skip=1 iff FGO=1.
- ION: IEN<=1. IOF: IEN<=0.
- Every io cycle asserts sc_clr.
- Input handshake: when in_valid & ~FGI, INPR<=in_data and FGI<=1.
- Input collision: INP clearing FGI in the same cycle does not accept a device byte, because in_ready uses the old FGI. Acceptance happens the following cycle.
- Output handshake: when out_valid & out_ready, FGO<=1.
- Output collision: if OUT and a device read of the old byte occur in the same cycle, OUT wins (FGO<=0, new byte) and no overrun is flagged.
- Interrupt detect: R<=1 at edge when R=0 & ~T[0] & ~T[1] & ~T[2] & IEN & (FGI|FGO). It uses the pre-edge IEN, so ION takes effect the next cycle.
- Interrupt cycle, with R=1 (all strobes are combinational):
  - T0: int_ar_clr=1, int_save_pc=1.
  - T1: int_save_pc=1, int_pc_clr=1.
  - T2: int_pc_inr=1, sc_clr=1. At the edge IEN<=0 and R<=0.
- io strobes are ignored while R=1.
- Reset mid-interrupt-cycle returns R=0 and normal fetch resumes at T0.
- All strobes are pure combinational functions of the current state and inputs; zero latency.

Decomposition:
- Shared package holds:
  - I/O function codes: IO_INP=4'h8, IO_OUT=4'h4, IO_SKI=4'h2, IO_SKO=4'h1, IO_ION=4'hC, IO_IOF=4'h3.
  - T/D index constants.
  - Reset values of FGI and FGO.
- One sub-module, io_flag_channel: a byte register plus a flag with device-side valid/ready, instantiated twice (input polarity and output polarity).
- The interrupt flip-flop and the decode logic stay in the top module.

Test Plan:
1. Reset, then idle -> fgi=0, fgo=1, ien=0, out_valid=0, in_ready=1, all strobes 0.
2. in_valid=1, in_data=8'h5A -> next cycle inpr=5A, fgi=1, in_ready=0. Then T3, D7, I=1, B=8 -> ac_ld_inpr=1, sc_clr=1, and fgi=0 after the edge.
3. ac_in=8'hC3, B=4 at io -> out_data=C3, out_valid=1. Second OUT with ac_in=8'h11 before out_ready -> out_overrun=1, out_data=11. Then out_ready=1 -> fgo=1.
4. SKI with fgi=0 -> pc_skip=0. SKI with fgi=1 -> pc_skip=1. SKO with fgo=1 -> pc_skip=1.
5. ION executed, fgo=1, SC advanced to T3 -> R=1 at the edge. Next T0/T1/T2 assert int_ar_clr+int_save_pc, then int_save_pc+int_pc_clr, then int_pc_inr+sc_clr. Afterwards ien=0 and R=0.
6. RST_N=0 pulsed during RT1 -> R=0, ien=0, fgo=1 next cycle; no interrupt strobes asserted.

Source files
------------

// File: rtl/io_interrupt_unit_pkg.sv
// io_interrupt_unit_pkg: I/O function codes, timing/decode indices and flag reset values
package io_interrupt_unit_pkg;
  localparam logic [3:0] IO_INP = 4'h8;
  localparam logic [3:0] IO_OUT = 4'h4;
  localparam logic [3:0] IO_SKI = 4'h2;
  localparam logic [3:0] IO_SKO = 4'h1;
  localparam logic [3:0] IO_ION = 4'hC;
  localparam logic [3:0] IO_IOF = 4'h3;
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int D7 = 7;
  localparam logic FGI_RST = 1'b0;
  localparam logic FGO_RST = 1'b1;
endpackage

// File: rtl/io_flag_channel.sv
// io_flag_channel: byte register plus full flag, write wins over read; INV exposes the flag as "empty"
module io_flag_channel #(
  parameter int DATA_W = 8,
  parameter bit INV = 1'b0,
  parameter bit OVERWRITE = 1'b0,
  parameter bit RST_FLAG = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] data,
  output logic              flag
);
  logic full, wr;
  assign wr = wr_valid & (OVERWRITE | ~full);
  assign flag = full ^ INV;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      data <= '0;
      full <= RST_FLAG ^ INV;
    end else begin
      if (wr) data <= wr_data;
      full <= wr ? 1'b1 : rd_ready ? 1'b0 : full;
    end
  end
endmodule

// File: rtl/io_interrupt_unit.sv
// io_interrupt_unit: Mano I/O decode, INPR/OUTR device handshakes and interrupt-cycle strobes
module io_interrupt_unit
  import io_interrupt_unit_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        T,
  input  logic [7:0]        D,
  input  logic              I,
  input  logic [ADDR_W-1:0] B,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] ac_in,
  output logic [DATA_W-1:0] inpr,
  output logic              ac_ld_inpr,
  output logic              pc_skip,
  output logic              sc_clr,
  output logic              fetch_inhibit,
  output logic              int_ar_clr,
  output logic              int_save_pc,
  output logic              int_pc_clr,
  output logic              int_pc_inr,
  output logic              ien,
  output logic              fgi,
  output logic              fgo,
  output logic              out_overrun
);
  logic r, io, inp, out_op, ski, sko, ion, iof, unused;
  assign unused = ^{T[7:4], D[6:0]};
  always_comb begin
    io = D[D7] & I & T[T3] & ~r;
    inp = io & (B == IO_INP);
    out_op = io & (B == IO_OUT);
    ski = io & (B == IO_SKI);
    sko = io & (B == IO_SKO);
    ion = io & (B == IO_ION);
    iof = io & (B == IO_IOF);
    in_ready = ~fgi;
    out_valid = ~fgo;
    ac_ld_inpr = inp;
    pc_skip = (ski & fgi) | (sko & fgo);
    sc_clr = io | (r & T[T2]);
    fetch_inhibit = r;
    int_ar_clr = r & T[T0];
    int_save_pc = r & (T[T0] | T[T1]);
    int_pc_clr = r & T[T1];
    int_pc_inr = r & T[T2];
    // a device read in the same cycle frees the old byte, so it is not an overrun
    out_overrun = out_op & ~fgo & ~out_ready;
  end
  io_flag_channel #(.DATA_W(DATA_W), .INV(1'b0), .OVERWRITE(1'b0), .RST_FLAG(FGI_RST)) u_in (
    .CLK(CLK), .RST_N(RST_N), .wr_valid(in_valid), .wr_data(in_data),
    .rd_ready(inp), .data(inpr), .flag(fgi)
  );
  io_flag_channel #(.DATA_W(DATA_W), .INV(1'b1), .OVERWRITE(1'b1), .RST_FLAG(FGO_RST)) u_out (
    .CLK(CLK), .RST_N(RST_N), .wr_valid(out_op), .wr_data(ac_in),
    .rd_ready(out_ready), .data(out_data), .flag(fgo)
  );
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r <= 1'b0;
      ien <= 1'b0;
    end else begin
      r <= r ? ~T[T2] : ~T[T0] & ~T[T1] & ~T[T2] & ien & (fgi | fgo);
      ien <= (r & T[T2]) ? 1'b0 : ion ? 1'b1 : iof ? 1'b0 : ien;
    end
  end
endmodule

// File: tb/tb_io_interrupt_unit.sv
// tb_io_interrupt_unit: directed scenarios plus random stimulus against a behavioural model
module tb_io_interrupt_unit;
  import io_interrupt_unit_pkg::*;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [7:0] T, D, in_data, ac_in;
  logic I, in_valid, out_ready;
  logic [3:0] B;
  logic in_ready, out_valid, ac_ld_inpr, pc_skip, sc_clr, fetch_inhibit;
  logic int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, ien, fgi, fgo, out_overrun;
  logic [7:0] out_data, inpr;
  int vectors = 0, miscompares = 0;
  logic [7:0] m_inpr = 8'h00, m_outr = 8'h00;
  logic m_fgi = 1'b0, m_fgo = 1'b1, m_ien = 1'b0, m_r = 1'b0;
  io_interrupt_unit dut (
    .CLK(CLK), .RST_N(RST_N), .T(T), .D(D), .I(I), .B(B),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ac_in(ac_in), .inpr(inpr), .ac_ld_inpr(ac_ld_inpr), .pc_skip(pc_skip),
    .sc_clr(sc_clr), .fetch_inhibit(fetch_inhibit), .int_ar_clr(int_ar_clr),
    .int_save_pc(int_save_pc), .int_pc_clr(int_pc_clr), .int_pc_inr(int_pc_inr),
    .ien(ien), .fgi(fgi), .fgo(fgo), .out_overrun(out_overrun)
  );
  always #5 CLK = ~CLK;
  wire [29:0] dut_vec = {in_ready, out_data, out_valid, inpr, ac_ld_inpr, pc_skip, sc_clr,
                         fetch_inhibit, int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr,
                         ien, fgi, fgo, out_overrun};
  function automatic logic [29:0] exp_vec();
    logic io;
    io = D[7] && I && T[3] && !m_r;
    return {!m_fgi, m_outr, !m_fgo, m_inpr, io && B == IO_INP,
            io && ((B == IO_SKI && m_fgi) || (B == IO_SKO && m_fgo)),
            io || (m_r && T[2]), m_r, m_r && T[0], m_r && (T[0] || T[1]),
            m_r && T[1], m_r && T[2], m_ien, m_fgi, m_fgo,
            io && B == IO_OUT && !m_fgo && !out_ready};
  endfunction
  task automatic model_edge();
    logic io, nr;
    if (!RST_N) begin
      m_inpr = 8'h00; m_outr = 8'h00; m_fgi = 1'b0; m_fgo = 1'b1; m_ien = 1'b0; m_r = 1'b0;
    end else begin
      io = D[7] && I && T[3] && !m_r;
      nr = m_r ? !T[2] : (!T[0] && !T[1] && !T[2] && m_ien && (m_fgi || m_fgo));
      if (m_r && T[2]) m_ien = 1'b0;
      else if (io && B == IO_ION) m_ien = 1'b1;
      else if (io && B == IO_IOF) m_ien = 1'b0;
      if (in_valid && !m_fgi) begin m_inpr = in_data; m_fgi = 1'b1; end
      else if (io && B == IO_INP) m_fgi = 1'b0;
      if (io && B == IO_OUT) begin m_outr = ac_in; m_fgo = 1'b0; end
      else if (!m_fgo && out_ready) m_fgo = 1'b1;
      m_r = nr;
    end
  endtask
  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    T = 8'h01; D = 8'h00; I = 1'b0; B = 4'h0; in_valid = 1'b0; out_ready = 1'b0;
  endtask
  task automatic set_io(input logic [3:0] b);
    T = 8'h08; D = 8'h80; I = 1'b1; B = b;
  endtask
  task automatic test_reset();
    RST_N = 1'b0; idle();
    tick(); tick();
    RST_N = 1'b1;
    #1;
    vectors++;
    if ({fgi, fgo, ien, out_valid, in_ready} !== 5'b01001) begin
      miscompares++; $display("FAIL reset_flags: got fgi/fgo/ien/ov/ir=%b want 01001", {fgi, fgo, ien, out_valid, in_ready});
    end
    vectors++;
    if ({ac_ld_inpr, pc_skip, sc_clr, fetch_inhibit, int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, out_overrun} !== 9'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 000000000", {ac_ld_inpr, pc_skip, sc_clr, fetch_inhibit, int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, out_overrun});
    end
    vectors++;
    if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL reset_vec: got %h want %h", dut_vec, exp_vec()); end
  endtask
  task automatic test_input();
    idle(); in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if ({inpr, fgi, in_ready} !== {8'h5A, 2'b10}) begin
      miscompares++; $display("FAIL input_accept: got inpr=%h fgi=%b ir=%b want 5a 1 0", inpr, fgi, in_ready);
    end
    set_io(IO_INP); in_valid = 1'b1; in_data = 8'h77;
    #1;
    vectors++;
    if ({ac_ld_inpr, sc_clr} !== 2'b11) begin
      miscompares++; $display("FAIL inp_strobe: got ld=%b sc_clr=%b want 1 1", ac_ld_inpr, sc_clr);
    end
    tick();
    T = 8'h01; D = 8'h00; I = 1'b0;
    #1;
    vectors++;
    if ({fgi, in_ready, inpr} !== {2'b01, 8'h5A}) begin
      miscompares++; $display("FAIL inp_collision: got fgi=%b ir=%b inpr=%h want 0 1 5a", fgi, in_ready, inpr);
    end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if ({fgi, inpr} !== {1'b1, 8'h77}) begin
      miscompares++; $display("FAIL input_retry: got fgi=%b inpr=%h want 1 77", fgi, inpr);
    end
  endtask
  task automatic test_output();
    idle(); ac_in = 8'hC3; set_io(IO_OUT);
    #1;
    vectors++;
    if (out_overrun !== 1'b0) begin miscompares++; $display("FAIL out_first_overrun: got %b want 0", out_overrun); end
    tick(); idle();
    #1;
    vectors++;
    if ({out_data, out_valid} !== {8'hC3, 1'b1}) begin
      miscompares++; $display("FAIL out_load: got data=%h valid=%b want c3 1", out_data, out_valid);
    end
    ac_in = 8'h11; set_io(IO_OUT);
    #1;
    vectors++;
    if (out_overrun !== 1'b1) begin miscompares++; $display("FAIL out_overrun: got %b want 1", out_overrun); end
    tick(); idle();
    #1;
    vectors++;
    if ({out_data, out_overrun} !== {8'h11, 1'b0}) begin
      miscompares++; $display("FAIL out_overwrite: got data=%h ovr=%b want 11 0", out_data, out_overrun);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    vectors++;
    if ({fgo, out_valid} !== 2'b10) begin miscompares++; $display("FAIL out_drain: got fgo=%b valid=%b want 1 0", fgo, out_valid); end
    ac_in = 8'hA5; set_io(IO_OUT);
    tick();
    ac_in = 8'h3C; out_ready = 1'b1;
    #1;
    vectors++;
    if (out_overrun !== 1'b0) begin miscompares++; $display("FAIL out_collision_ovr: got %b want 0", out_overrun); end
    tick(); idle();
    #1;
    vectors++;
    if ({fgo, out_data} !== {1'b0, 8'h3C}) begin
      miscompares++; $display("FAIL out_collision: got fgo=%b data=%h want 0 3c", fgo, out_data);
    end
    out_ready = 1'b1;
    tick();
    idle();
  endtask
  task automatic test_skip();
    set_io(IO_INP);
    tick();
    set_io(IO_SKI);
    #1;
    vectors++;
    if (pc_skip !== 1'b0) begin miscompares++; $display("FAIL ski_clear: got %b want 0", pc_skip); end
    tick();
    idle(); in_valid = 1'b1; in_data = 8'($urandom);
    tick();
    in_valid = 1'b0; set_io(IO_SKI);
    #1;
    vectors++;
    if (pc_skip !== 1'b1) begin miscompares++; $display("FAIL ski_set: got %b want 1", pc_skip); end
    tick();
    set_io(IO_SKO);
    #1;
    vectors++;
    if (pc_skip !== 1'b1) begin miscompares++; $display("FAIL sko_set: got %b want 1", pc_skip); end
    vectors++;
    if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL sko_vec: got %h want %h", dut_vec, exp_vec()); end
    tick();
  endtask
  task automatic test_interrupt();
    set_io(IO_ION);
    tick();
    T = 8'h08; D = 8'h00; I = 1'b0;
    #1;
    vectors++;
    if ({ien, fetch_inhibit} !== 2'b10) begin
      miscompares++; $display("FAIL ion_enable: got ien=%b fi=%b want 1 0", ien, fetch_inhibit);
    end
    tick();
    set_io(IO_INP);
    #1;
    vectors++;
    if ({fetch_inhibit, ac_ld_inpr, sc_clr} !== 3'b100) begin
      miscompares++; $display("FAIL int_io_masked: got fi/ld/sc=%b want 100", {fetch_inhibit, ac_ld_inpr, sc_clr});
    end
    tick();
    T = 8'h01; D = 8'h00; I = 1'b0;
    #1;
    vectors++;
    if ({fgi, int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, sc_clr} !== 6'b111000) begin
      miscompares++; $display("FAIL int_rt0: got fgi/ar/save/pcclr/inr/sc=%b want 111000", {fgi, int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, sc_clr});
    end
    tick();
    T = 8'h02;
    #1;
    vectors++;
    if ({int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, sc_clr} !== 5'b01100) begin
      miscompares++; $display("FAIL int_rt1: got ar/save/pcclr/inr/sc=%b want 01100", {int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, sc_clr});
    end
    tick();
    T = 8'h04;
    #1;
    vectors++;
    if ({int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, sc_clr} !== 5'b00011) begin
      miscompares++; $display("FAIL int_rt2: got ar/save/pcclr/inr/sc=%b want 00011", {int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr, sc_clr});
    end
    tick();
    idle();
    #1;
    vectors++;
    if ({ien, fetch_inhibit, int_save_pc} !== 3'b000) begin
      miscompares++; $display("FAIL int_exit: got ien/fi/save=%b want 000", {ien, fetch_inhibit, int_save_pc});
    end
  endtask
  task automatic test_reset_mid();
    set_io(IO_ION);
    tick();
    T = 8'h08; D = 8'h00; I = 1'b0;
    tick();
    T = 8'h01;
    tick();
    T = 8'h02;
    #1;
    vectors++;
    if (int_pc_clr !== 1'b1) begin miscompares++; $display("FAIL mid_rt1: got %b want 1", int_pc_clr); end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1; idle();
    #1;
    vectors++;
    if ({fetch_inhibit, ien, fgo, int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr} !== 7'b0010000) begin
      miscompares++; $display("FAIL mid_reset: got fi/ien/fgo/strobes=%b want 0010000", {fetch_inhibit, ien, fgo, int_ar_clr, int_save_pc, int_pc_clr, int_pc_inr});
    end
  endtask
  task automatic test_random();
    logic [3:0] codes [7];
    codes = '{IO_INP, IO_OUT, IO_SKI, IO_SKO, IO_ION, IO_IOF, 4'h0};
    for (int n = 0; n < 3000; n++) begin
      RST_N = ($urandom_range(0, 199) != 0);
      T = 8'h01 << $urandom_range(0, 7);
      D = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h01 << $urandom_range(0, 7);
      I = 1'($urandom_range(0, 1));
      codes[6] = 4'($urandom);
      B = codes[$urandom_range(0, 6)];
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      ac_in = 8'($urandom);
      #1;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL random_%0d: got %h want %h", n, dut_vec, exp_vec());
      end
      tick();
    end
    RST_N = 1'b1;
    idle();
  endtask
  initial begin
    idle(); ac_in = 8'h00; in_data = 8'h00;
    #2;
    test_reset();
    test_input();
    test_output();
    test_skip();
    test_interrupt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
